// File: rtl/lii_stream_adapter.sv
// LII-to-HLS stream adapter: gathers PW-wide LII beats into kernel input words and
// serialises FIFO-buffered kernel results back onto LII, with headroom-driven kernel ce.
module lii_stream_adapter #(
    parameter int unsigned PW         = 1024,
    parameter int unsigned IN_W       = 192,
    parameter int unsigned OUT_W      = 384,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [7:0]  MY_ID      = 8'h00,
    parameter logic [7:0]  DST_ID     = 8'h01
) (
    input  logic             aclk,
    input  logic             arstn,
    input  logic [PW-1:0]    lii_in_tdata,
    input  logic             lii_in_tvalid,
    output logic             lii_in_tready,
    input  logic [7:0]       lii_in_src,
    input  logic [7:0]       lii_in_dst,
    output logic [PW-1:0]    lii_out_tdata,
    output logic             lii_out_tvalid,
    input  logic             lii_out_tready,
    output logic [7:0]       lii_out_src,
    output logic [7:0]       lii_out_dst,
    output logic [IN_W-1:0]  in_stream_tdata,
    output logic             in_stream_tvalid,
    input  logic             in_stream_tready,
    input  logic [OUT_W-1:0] out_stream_tdata,
    input  logic             out_stream_tvalid,
    output logic             out_stream_tready,
    output logic             ce,
    output logic [15:0]      drop_cnt
);
    localparam int unsigned IN_BEATS  = (IN_W + PW - 1) / PW;
    localparam int unsigned OUT_BEATS = (OUT_W + PW - 1) / PW;
    localparam int unsigned GW        = IN_BEATS * PW;
    localparam int unsigned SW        = OUT_BEATS * PW;
    localparam int unsigned IBW       = (IN_BEATS > 1) ? $clog2(IN_BEATS) : 1;
    localparam int unsigned OBW       = (OUT_BEATS > 1) ? $clog2(OUT_BEATS) : 1;
    localparam int unsigned PTRW      = $clog2(FIFO_DEPTH);
    localparam int unsigned CW        = PTRW + 1;

    localparam logic [IBW-1:0] IN_LAST  = IBW'(IN_BEATS - 1);
    localparam logic [OBW-1:0] OUT_LAST = OBW'(OUT_BEATS - 1);
    localparam logic [CW-1:0]  FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0]  CE_MAX   = CW'(FIFO_DEPTH - 2);

    typedef enum logic [0:0] {IN_GATHER = 1'b0, IN_HOLD = 1'b1} in_state_t;
    typedef enum logic [0:0] {OUT_IDLE = 1'b0, OUT_SEND = 1'b1} out_state_t;

    in_state_t        in_state_r, in_state_next_s;
    out_state_t       out_state_r, out_state_next_s;
    logic [IBW-1:0]   in_beat_r;
    logic [OBW-1:0]   out_beat_r;
    logic [GW-1:0]    gather_r;
    logic [SW-1:0]    ser_r;
    logic [OUT_W-1:0] fifo_mem_r [FIFO_DEPTH];
    logic [PTRW-1:0]  wr_ptr_r, rd_ptr_r, rd_next_s;
    logic [CW-1:0]    count_r, count_next_s;
    logic             in_hs_s, beat_ok_s, drop_s;
    logic             push_s, pop_s, out_hs_s, load_s;
    logic [OUT_W-1:0] load_word_s;
    logic             unused_s;

    assign in_stream_tvalid  = (in_state_r == IN_HOLD);
    assign lii_in_tready     = (in_state_r == IN_GATHER);
    assign in_stream_tdata   = gather_r[IN_W-1:0];
    assign lii_out_tvalid    = (out_state_r == OUT_SEND);
    assign lii_out_tdata     = ser_r[PW-1:0];
    assign lii_out_src       = MY_ID;
    assign lii_out_dst       = DST_ID;
    assign out_stream_tready = (count_r != FULL_CNT);
    assign rd_next_s         = rd_ptr_r + PTRW'(1);
    assign unused_s          = ^{lii_in_src, gather_r};

    // Input handshake classification and gather/hold next state.
    always_comb begin
        in_state_next_s = in_state_r;
        in_hs_s         = lii_in_tvalid & lii_in_tready;
        beat_ok_s       = in_hs_s & (lii_in_dst == MY_ID);
        drop_s          = in_hs_s & (lii_in_dst != MY_ID);
        case (in_state_r)
            IN_GATHER: begin
                if (beat_ok_s && (in_beat_r == IN_LAST)) begin
                    in_state_next_s = IN_HOLD;
                end else begin
                    in_state_next_s = IN_GATHER;
                end
            end
            IN_HOLD: begin
                if (in_stream_tready) begin
                    in_state_next_s = IN_GATHER;
                end else begin
                    in_state_next_s = IN_HOLD;
                end
            end
            default: in_state_next_s = IN_GATHER;
        endcase
    end

    // Input state, beat counter, gather register and drop counter.
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            in_state_r <= IN_GATHER;
            in_beat_r  <= IBW'(0);
            gather_r   <= GW'(0);
            drop_cnt   <= 16'h0000;
        end else begin
            in_state_r <= in_state_next_s;
            if (beat_ok_s) begin
                for (int b = 0; b < IN_BEATS; b++) begin
                    if (in_beat_r == IBW'(b)) begin
                        gather_r[b*PW +: PW] <= lii_in_tdata;
                    end
                end
                in_beat_r <= (in_beat_r == IN_LAST) ? IBW'(0) : in_beat_r + IBW'(1);
            end
            if (drop_s && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'h0001;
            end
        end
    end

    // FIFO occupancy and serialiser next state; an empty FIFO bypasses the incoming push.
    always_comb begin
        push_s           = out_stream_tvalid & out_stream_tready;
        out_hs_s         = lii_out_tvalid & lii_out_tready;
        pop_s            = out_hs_s & (out_beat_r == OUT_LAST);
        out_state_next_s = out_state_r;
        load_s           = 1'b0;
        load_word_s      = fifo_mem_r[rd_ptr_r];
        if (push_s && !pop_s) begin
            count_next_s = count_r + CW'(1);
        end else if (!push_s && pop_s) begin
            count_next_s = count_r - CW'(1);
        end else begin
            count_next_s = count_r;
        end
        case (out_state_r)
            OUT_IDLE: begin
                if (count_r != CW'(0)) begin
                    load_s           = 1'b1;
                    load_word_s      = fifo_mem_r[rd_ptr_r];
                    out_state_next_s = OUT_SEND;
                end else if (push_s) begin
                    load_s           = 1'b1;
                    load_word_s      = out_stream_tdata;
                    out_state_next_s = OUT_SEND;
                end else begin
                    out_state_next_s = OUT_IDLE;
                end
            end
            OUT_SEND: begin
                if (pop_s && (count_r >= CW'(2))) begin
                    load_s           = 1'b1;
                    load_word_s      = fifo_mem_r[rd_next_s];
                    out_state_next_s = OUT_SEND;
                end else if (pop_s && push_s) begin
                    load_s           = 1'b1;
                    load_word_s      = out_stream_tdata;
                    out_state_next_s = OUT_SEND;
                end else if (pop_s) begin
                    out_state_next_s = OUT_IDLE;
                end else begin
                    out_state_next_s = OUT_SEND;
                end
            end
            default: out_state_next_s = OUT_IDLE;
        endcase
    end

    // FIFO storage; contents need no reset since pointers gate every read.
    always_ff @(posedge aclk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= out_stream_tdata;
        end
    end

    // FIFO pointers, serialiser shift register and registered clock enable.
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            wr_ptr_r    <= PTRW'(0);
            rd_ptr_r    <= PTRW'(0);
            count_r     <= CW'(0);
            out_state_r <= OUT_IDLE;
            out_beat_r  <= OBW'(0);
            ser_r       <= SW'(0);
            ce          <= 1'b0;
        end else begin
            count_r     <= count_next_s;
            out_state_r <= out_state_next_s;
            ce          <= (count_next_s <= CE_MAX);
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTRW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_next_s;
            end
            if (load_s) begin
                ser_r      <= SW'(load_word_s);
                out_beat_r <= OBW'(0);
            end else if (out_hs_s) begin
                ser_r      <= ser_r >> PW;
                out_beat_r <= pop_s ? OBW'(0) : out_beat_r + OBW'(1);
            end
        end
    end
endmodule

// File: tb/tb_lii_stream_adapter.sv
// Randomised bench for lii_stream_adapter (PW=128, IN_W=192, OUT_W=384) against a queue-based model.
module tb_lii_stream_adapter;
    localparam int PW        = 128;
    localparam int IN_W      = 192;
    localparam int OUT_W     = 384;
    localparam int FD        = 4;
    localparam int IN_BEATS  = 2;
    localparam int OUT_BEATS = 3;
    localparam logic [7:0] MY_ID  = 8'h00;
    localparam logic [7:0] DST_ID = 8'h01;

    logic             aclk = 1'b0;
    logic             arstn = 1'b0;
    logic [PW-1:0]    lii_in_tdata = '0;
    logic             lii_in_tvalid = 1'b0;
    logic             lii_in_tready;
    logic [7:0]       lii_in_src = 8'h00;
    logic [7:0]       lii_in_dst = 8'h00;
    logic [PW-1:0]    lii_out_tdata;
    logic             lii_out_tvalid;
    logic             lii_out_tready = 1'b0;
    logic [7:0]       lii_out_src;
    logic [7:0]       lii_out_dst;
    logic [IN_W-1:0]  in_stream_tdata;
    logic             in_stream_tvalid;
    logic             in_stream_tready = 1'b0;
    logic [OUT_W-1:0] out_stream_tdata = '0;
    logic             out_stream_tvalid = 1'b0;
    logic             out_stream_tready;
    logic             ce;
    logic [15:0]      drop_cnt;

    lii_stream_adapter #(
        .PW(PW), .IN_W(IN_W), .OUT_W(OUT_W), .FIFO_DEPTH(FD), .MY_ID(MY_ID), .DST_ID(DST_ID)
    ) dut (
        .aclk(aclk), .arstn(arstn),
        .lii_in_tdata(lii_in_tdata), .lii_in_tvalid(lii_in_tvalid), .lii_in_tready(lii_in_tready),
        .lii_in_src(lii_in_src), .lii_in_dst(lii_in_dst),
        .lii_out_tdata(lii_out_tdata), .lii_out_tvalid(lii_out_tvalid), .lii_out_tready(lii_out_tready),
        .lii_out_src(lii_out_src), .lii_out_dst(lii_out_dst),
        .in_stream_tdata(in_stream_tdata), .in_stream_tvalid(in_stream_tvalid),
        .in_stream_tready(in_stream_tready),
        .out_stream_tdata(out_stream_tdata), .out_stream_tvalid(out_stream_tvalid),
        .out_stream_tready(out_stream_tready),
        .ce(ce), .drop_cnt(drop_cnt)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    logic [PW-1:0]    part_q [$];
    logic [IN_W-1:0]  kin_q  [$];
    logic [OUT_W-1:0] out_q  [$];
    int out_beat = 0;
    int drops = 0;
    int since_rst = 0;
    int p_in_valid = 0, p_bad_dst = 0, p_kin_ready = 0, p_kout_valid = 0, p_out_ready = 0;

    task automatic check_value(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [OUT_W-1:0] rand_word();
        logic [OUT_W-1:0] w;
        for (int i = 0; i < OUT_W / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    function automatic bit chance(input int pct);
        return ($urandom_range(99) < pct);
    endfunction

    task automatic drive_inputs();
        logic [OUT_W-1:0] w;
        w = rand_word();
        lii_in_tdata      = w[PW-1:0];
        lii_in_tvalid     = chance(p_in_valid);
        lii_in_dst        = chance(p_bad_dst) ? 8'h07 : MY_ID;
        lii_in_src        = 8'($urandom);
        in_stream_tready  = chance(p_kin_ready);
        out_stream_tvalid = chance(p_kout_valid);
        out_stream_tdata  = rand_word();
        lii_out_tready    = chance(p_out_ready);
    endtask

    // Compare outputs with the model, then advance the model by the handshakes of the coming edge.
    task automatic check_cycle();
        logic [OUT_BEATS*PW-1:0] padded;
        logic [IN_BEATS*PW-1:0]  g;
        bit push_ok;
        check_value("lii_in_tready", lii_in_tready, kin_q.size() == 0);
        check_value("in_tvalid", in_stream_tvalid, kin_q.size() != 0);
        if (kin_q.size() != 0) check_value("in_tdata", in_stream_tdata, kin_q[0]);
        check_value("drop_cnt", drop_cnt, drops);
        check_value("out_stream_tready", out_stream_tready, out_q.size() != FD);
        check_value("out_tvalid", lii_out_tvalid, out_q.size() != 0);
        if (out_q.size() != 0) begin
            padded = out_q[0];
            check_value("out_tdata", lii_out_tdata, padded[out_beat*PW +: PW]);
            check_value("out_src", lii_out_src, MY_ID);
            check_value("out_dst", lii_out_dst, DST_ID);
        end
        if (since_rst > 0) check_value("ce", ce, out_q.size() <= FD - 2);

        if (lii_in_tvalid && kin_q.size() == 0) begin
            if (lii_in_dst == MY_ID) begin
                part_q.push_back(lii_in_tdata);
                if (part_q.size() == IN_BEATS) begin
                    for (int i = 0; i < IN_BEATS; i++) g[i*PW +: PW] = part_q[i];
                    kin_q.push_back(g[IN_W-1:0]);
                    part_q.delete();
                end
            end else if (drops < 65535) begin
                drops++;
            end
        end else if (in_stream_tready && kin_q.size() != 0) begin
            void'(kin_q.pop_front());
        end

        push_ok = out_stream_tvalid && (out_q.size() != FD);
        if (lii_out_tready && out_q.size() != 0) begin
            out_beat++;
            if (out_beat == OUT_BEATS) begin
                void'(out_q.pop_front());
                out_beat = 0;
            end
        end
        if (push_ok) out_q.push_back(out_stream_tdata);
    endtask

    task automatic step();
        @(posedge aclk);
        if (arstn) since_rst++;
        #1 drive_inputs();
        @(negedge aclk);
        check_cycle();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_mix(input int iv, input int bd, input int kr, input int kv, input int orr);
        p_in_valid = iv; p_bad_dst = bd; p_kin_ready = kr; p_kout_valid = kv; p_out_ready = orr;
    endtask

    // Asynchronous reset mid-cycle; outputs must clear without waiting for a clock edge.
    task automatic apply_reset();
        #2 arstn = 1'b0;
        lii_in_tvalid = 1'b0; out_stream_tvalid = 1'b0;
        lii_out_tready = 1'b0; in_stream_tready = 1'b0;
        #1;
        check_value("rst_in_tvalid", in_stream_tvalid, 1'b0);
        check_value("rst_out_tvalid", lii_out_tvalid, 1'b0);
        check_value("rst_ce", ce, 1'b0);
        check_value("rst_drop_cnt", drop_cnt, 16'h0000);
        check_value("rst_lii_in_tready", lii_in_tready, 1'b1);
        check_value("rst_out_stream_tready", out_stream_tready, 1'b1);
        part_q.delete(); kin_q.delete(); out_q.delete();
        out_beat = 0; drops = 0; since_rst = 0;
        repeat (2) @(negedge aclk);
        arstn = 1'b1;
    endtask

    initial begin
        apply_reset();
        set_mix(100, 0, 100, 0, 0);   run(20);
        set_mix(60, 20, 50, 50, 50);  run(1500);
        set_mix(0, 0, 100, 100, 0);   run(10);
        set_mix(0, 0, 100, 0, 100);   run(20);
        set_mix(50, 30, 30, 70, 30);  run(400);
        set_mix(100, 0, 0, 100, 0);   run(2);
        apply_reset();
        set_mix(60, 20, 50, 50, 60);  run(400);
        set_mix(100, 100, 100, 0, 100); run(65540);
        check_value("drop_cnt_saturated", drop_cnt, 16'hFFFF);
        apply_reset();
        set_mix(70, 10, 60, 60, 70);  run(200);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
